// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I R-type multicycle controller: FSM states, ALU selects, trap causes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_TRAP      = 3'd4
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/rv_alu_decoder.sv
// R-type opcode/funct3/funct7 to 4-bit ALU select; purely combinational, zero latency.
// legal=0 for any non R-type opcode or unlisted funct7/funct3 pair.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluControl,
    output logic       legal
);

    logic w_base;
    logic w_alt;

    assign w_base = (funct7 == FUNCT7_BASE);
    assign w_alt  = (funct7 == FUNCT7_ALT);

    always_comb begin
        aluControl = ALU_ADD;
        legal      = 1'b0;
        if (opcode == OPCODE_RTYPE) begin
            case (funct3)
                3'b000: begin
                    legal      = w_base | w_alt;
                    aluControl = w_alt ? ALU_SUB : ALU_ADD;
                end
                3'b001: begin
                    legal      = w_base;
                    aluControl = ALU_SLL;
                end
                3'b101: begin
                    legal      = w_base | w_alt;
                    aluControl = w_alt ? ALU_SRA : ALU_SRL;
                end
                3'b010: begin
                    legal      = w_base;
                    aluControl = ALU_SLT;
                end
                3'b011: begin
                    legal      = w_base;
                    aluControl = ALU_SLTU;
                end
                3'b100: begin
                    legal      = w_base;
                    aluControl = ALU_XOR;
                end
                3'b110: begin
                    legal      = w_base;
                    aluControl = ALU_OR;
                end
                3'b111: begin
                    legal      = w_base;
                    aluControl = ALU_AND;
                end
                default: begin
                    legal      = 1'b0;
                    aluControl = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R-type datapath; 4 cycles per instruction.
// Fetch stalls while imemValid is low, trapping after FETCH_TIMEOUT idle cycles; TRAP is absorbing.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      imemRdata,
    input  logic             imemValid,
    output logic             imemReq,
    output logic [31:0]      instrCode,
    output logic [3:0]       aluControl,
    output logic             regFileWe,
    output logic             pcEn,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned      TO_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    state_e           r_state;
    logic [31:0]      r_ir;
    logic [3:0]       r_alu;
    logic             r_we;
    logic             r_pc_en;
    logic             r_trap;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;
    logic [TO_W-1:0]  r_to_cnt;

    logic [3:0]       w_alu;
    logic             w_legal;

    rv_alu_decoder u_dec (
        .opcode     (r_ir[6:0]),
        .funct3     (r_ir[14:12]),
        .funct7     (r_ir[31:25]),
        .aluControl (w_alu),
        .legal      (w_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_alu     <= ALU_ADD;
            r_we      <= 1'b0;
            r_pc_en   <= 1'b0;
            r_trap    <= 1'b0;
            r_cause   <= TRAP_NONE;
            r_retired <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imemValid) begin
                        r_ir     <= imemRdata;
                        r_to_cnt <= '0;
                        r_state  <= ST_DECODE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_trap  <= 1'b1;
                        r_cause <= TRAP_TIMEOUT;
                        r_state <= ST_TRAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_alu   <= w_alu;
                        r_state <= ST_EXECUTE;
                    end else begin
                        r_trap  <= 1'b1;
                        r_cause <= TRAP_ILLEGAL;
                        r_state <= ST_TRAP;
                    end
                end
                ST_EXECUTE: begin
                    // Writes to x0 are suppressed here so the datapath never sees them.
                    r_we    <= (r_ir[11:7] != 5'd0);
                    r_pc_en <= 1'b1;
                    r_state <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    r_we      <= 1'b0;
                    r_pc_en   <= 1'b0;
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_we    <= 1'b0;
                    r_pc_en <= 1'b0;
                end
                default: begin
                    r_state <= ST_TRAP;
                end
            endcase
        end
    end

    assign imemReq    = (r_state == ST_FETCH);
    assign instrCode  = r_ir;
    assign aluControl = r_alu;
    assign regFileWe  = r_we;
    assign pcEn       = r_pc_en;
    assign trap       = r_trap;
    assign trapCause  = r_cause;
    assign retired    = r_retired;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes expected retire/trap events, a negedge monitor checks them.
module tb_rv_multicycle_ctrl;

    localparam int unsigned TO    = 16;
    localparam int unsigned CNT_W = 32;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic [31:0]      imemRdata = '0;
    logic             imemValid = 1'b0;
    logic             imemReq;
    logic [31:0]      instrCode;
    logic [3:0]       aluControl;
    logic             regFileWe;
    logic             pcEn;
    logic             trap;
    logic [1:0]       trapCause;
    logic [CNT_W-1:0] retired;

    rv_multicycle_ctrl #(.FETCH_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .imemRdata  (imemRdata),
        .imemValid  (imemValid),
        .imemReq    (imemReq),
        .instrCode  (instrCode),
        .aluControl (aluControl),
        .regFileWe  (regFileWe),
        .pcEn       (pcEn),
        .trap       (trap),
        .trapCause  (trapCause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        is_trap;
        logic [31:0] instr;
        logic [3:0]  alu;
        logic        we;
        logic [31:0] ret;
        logic [1:0]  cause;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [31:0] exp_ret   = '0;
    logic        prev_trap = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every pcEn pulse and every trap rising edge must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            prev_trap = 1'b0;
        end else begin
            if (regFileWe) chk("we_with_pc", {63'd0, pcEn}, 64'd1);
            if (pcEn) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pc_pulse: got pcEn=1, expected no pulse (cycle %0d)", cyc);
                end else begin
                    m_e = sb.pop_front();
                    chk("event_kind_retire", {63'd0, m_e.is_trap}, 64'd0);
                    chk("alu",        {60'd0, aluControl}, {60'd0, m_e.alu});
                    chk("we",         {63'd0, regFileWe},  {63'd0, m_e.we});
                    chk("ir",         {32'd0, instrCode},  {32'd0, m_e.instr});
                    chk("retired_wb", {32'd0, retired},    {32'd0, m_e.ret});
                    chk("pc_cycle",   64'(cyc),            {32'd0, m_e.cyc});
                end
            end
            if (trap && !prev_trap) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_trap: got trap=1 cause=%0d, expected no trap (cycle %0d)", trapCause, cyc);
                end else begin
                    m_e = sb.pop_front();
                    chk("event_kind_trap", {63'd0, m_e.is_trap}, 64'd1);
                    chk("trap_cause", {62'd0, trapCause}, {62'd0, m_e.cause});
                    chk("trap_ir",    {32'd0, instrCode}, {32'd0, m_e.instr});
                    chk("trap_cycle", 64'(cyc),           {32'd0, m_e.cyc});
                end
            end
            prev_trap = trap;
        end
    end

    task automatic wait_req();
        int n = 0;
        @(negedge clk);
        while (!imemReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imemReq) chk("fetch_wait_timeout", {63'd0, imemReq}, 64'd1);
    endtask

    // Presents one word after `waits` idle FETCH cycles; returns the FETCH cycle in which it was accepted.
    task automatic issue(input logic [31:0] w, input int waits, input logic [3:0] alu,
                         input logic legal, input logic push, output int k);
        exp_t e;
        wait_req();
        repeat (waits) @(negedge clk);
        imemValid = 1'b1;
        imemRdata = w;
        k = cyc;
        if (push) begin
            if (legal) begin
                e = '{1'b0, w, alu, (w[11:7] != 5'd0), exp_ret, 2'b00, 32'(k + 3)};
                exp_ret++;
            end else begin
                e = '{1'b1, w, 4'd0, 1'b0, 32'd0, 2'b01, 32'(k + 2)};
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        imemValid = 1'b0;
        imemRdata = $urandom;
        @(negedge clk);
        chk("req_drops_after_fetch", {63'd0, imemReq}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_trap",    {63'd0, trap},      64'd0);
        chk("rst_cause",   {62'd0, trapCause}, 64'd0);
        chk("rst_retired", {32'd0, retired},   64'd0);
        reset   = 1'b1;
        exp_ret = '0;
    endtask

    logic [31:0] tw [10] = '{32'h002091B3, 32'h0020D1B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
                             32'h0020E1B3, 32'h0020F1B3, 32'h407302B3, 32'h4020D233, 32'h00208033};
    logic [3:0]  ta [10] = '{4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
                             4'b1000, 4'b1001, 4'b0001, 4'b0100, 4'b0000};

    initial begin
        int k, k_prev, n;
        #12;
        chk("rst_req",     {63'd0, imemReq},    64'd1);
        chk("rst_ir",      {32'd0, instrCode},  64'd0);
        chk("rst_alu",     {60'd0, aluControl}, 64'd0);
        chk("rst_we",      {63'd0, regFileWe},  64'd0);
        chk("rst_pc",      {63'd0, pcEn},       64'd0);
        chk("rst_trap",    {63'd0, trap},       64'd0);
        chk("rst_cause",   {62'd0, trapCause},  64'd0);
        chk("rst_retired", {32'd0, retired},    64'd0);
        @(negedge clk);
        reset = 1'b1;

        // add x3,x1,x2 with valid on the first FETCH cycle
        issue(32'h002081B3, 0, 4'b0000, 1'b1, 1'b1, k);
        wait_req();
        chk("retired_after_add", {32'd0, retired}, 64'd1);

        // Back-to-back R-type table: every ALU op, plus an rd=x0 write
        k_prev = -1;
        for (int i = 0; i < 10; i++) begin
            issue(tw[i], 0, ta[i], 1'b1, 1'b1, k);
            if (k_prev >= 0) chk("throughput_4cyc", 64'(k - k_prev), 64'd4);
            k_prev = k;
        end
        wait_req();
        chk("retired_after_table", {32'd0, retired}, {32'd0, exp_ret});

        // Valid arrives on the 15th FETCH cycle: no timeout, normal retire
        issue(32'h0020C1B3, 14, 4'b0111, 1'b1, 1'b1, k);
        wait_req();
        chk("retired_after_late", {32'd0, retired}, {32'd0, exp_ret});

        // Reset during EXECUTE aborts the instruction with no write or PC pulse
        issue(32'h002081B3, 0, 4'b0000, 1'b1, 1'b0, k);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_we",      {63'd0, regFileWe},  64'd0);
        chk("abort_pc",      {63'd0, pcEn},       64'd0);
        chk("abort_ir",      {32'd0, instrCode},  64'd0);
        chk("abort_alu",     {60'd0, aluControl}, 64'd0);
        chk("abort_retired", {32'd0, retired},    64'd0);
        chk("abort_req",     {63'd0, imemReq},    64'd1);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        exp_ret = '0;
        issue(32'h407302B3, 0, 4'b0001, 1'b1, 1'b1, k);
        wait_req();
        chk("retired_after_abort", {32'd0, retired}, 64'd1);

        // addi is not R-type: trap cause 01, then fully quiet despite valid words
        issue(32'h00000013, 0, 4'd0, 1'b0, 1'b1, k);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("trap_quiet", {59'd0, imemReq, regFileWe, pcEn, trap, (instrCode == 32'h13)}, 64'b00011);
            imemValid = 1'b1;
            imemRdata = 32'h002081B3;
        end
        imemValid = 1'b0;
        chk("trap_retired_held", {32'd0, retired}, 64'd1);

        // funct7=0x20 with sll is an unlisted pair
        do_reset();
        issue(32'h402091B3, 0, 4'd0, 1'b0, 1'b1, k);
        repeat (3) @(negedge clk);

        // Fetch timeout after one good instruction; IR keeps the last good word
        do_reset();
        issue(32'h002081B3, 0, 4'b0000, 1'b1, 1'b1, k);
        wait_req();
        sb.push_back('{1'b1, 32'h002081B3, 4'd0, 1'b0, 32'd0, 2'b10, 32'(cyc + TO)});
        n = 0;
        while (!trap && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_trap_seen", {63'd0, trap}, 64'd1);
        repeat (3) @(negedge clk);
        chk("timeout_req_low", {63'd0, imemReq}, 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
